// File: rtl/sw_target_feeder.sv
// sw_target_feeder: head-end driver for the Smith-Waterman systolic PE chain.
//
// Loads one target sequence of 2-bit bases from an upstream valid/ready stream
// into a local buffer. It then drives the sequence into the first PE as one
// unbroken enable burst, with biased-zero boundary scores. It waits for the last
// PE's valid flag and returns the unbiased high score on a valid/ready result
// port. Only one sequence is in flight at a time.
//
// Optional build macro:
//   SW_FEEDER_TIMEOUT_EN - adds a watchdog while waiting for the chain's valid.
//                          On expiry the result is 0 and res_err is set.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   s_valid/s_ready     upstream base handshake; s_base = base, s_last = final base
//   pe_en, pe_data      en_in/data_in of the first PE
//   pe_M, pe_I, pe_High boundary scores into the first PE (constant ZERO)
//   pe_high_in          High_out of the last PE
//   pe_vld_in           vld of the last PE
//   res_valid/res_ready result handshake; res_score, res_len, res_err payload
//   busy                feeder is not idle
module sw_target_feeder #(
  parameter int unsigned SCORE_WIDTH = 12,
  parameter int unsigned ZERO        = 2 ** (SCORE_WIDTH - 1),
  parameter int unsigned NUM_PE      = 16,
  parameter int unsigned BUF_DEPTH   = 256,
  parameter int unsigned LEN_WIDTH   = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [1:0]             s_base,
  input  logic                   s_last,
  output logic                   pe_en,
  output logic [1:0]             pe_data,
  output logic [SCORE_WIDTH-1:0] pe_M,
  output logic [SCORE_WIDTH-1:0] pe_I,
  output logic [SCORE_WIDTH-1:0] pe_High,
  input  logic [SCORE_WIDTH-1:0] pe_high_in,
  input  logic                   pe_vld_in,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic [LEN_WIDTH-1:0]   res_len,
  output logic                   res_err,
  output logic                   busy
);

  localparam int unsigned AddrWidth = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [SCORE_WIDTH-1:0] ZeroScore = SCORE_WIDTH'(ZERO);
  localparam logic [LEN_WIDTH-1:0] DepthLen = LEN_WIDTH'(BUF_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LastIdx = LEN_WIDTH'(BUF_DEPTH - 1);
  localparam logic [AddrWidth-1:0] FirstAddr = '0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDrain,
    StStream,
    StWaitVld,
    StResult
  } state_e;

  state_e                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic                   ovf_q, ovf_d;
  logic                   pe_en_q, pe_en_d;
  logic [1:0]             pe_data_q, pe_data_d;
  logic                   res_valid_q, res_valid_d;
  logic [SCORE_WIDTH-1:0] res_score_q, res_score_d;
  logic [LEN_WIDTH-1:0]   res_len_q, res_len_d;
  logic                   res_err_q, res_err_d;
  logic                   mem_we;
  logic                   start_stream;
  logic                   timeout_q;

  logic [1:0] mem [BUF_DEPTH];

`ifdef SW_FEEDER_TIMEOUT_EN
  localparam int unsigned WdWidth = $clog2(BUF_DEPTH + 2 * NUM_PE + 9);
  logic [WdWidth-1:0] wd_q, wd_d, wd_limit;
  logic               timeout_d;

  assign wd_limit = WdWidth'(len_q) + WdWidth'(2 * NUM_PE + 8);
`else
  assign timeout_q = 1'b0;
`endif

  assign s_ready   = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDrain);
  assign busy      = (state_q != StIdle);
  assign pe_en     = pe_en_q;
  assign pe_data   = pe_data_q;
  assign pe_M      = ZeroScore;
  assign pe_I      = ZeroScore;
  assign pe_High   = ZeroScore;
  assign res_valid = res_valid_q;
  assign res_score = res_score_q;
  assign res_len   = res_len_q;
  assign res_err   = res_err_q;

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    len_d        = len_q;
    rd_ptr_d     = rd_ptr_q;
    ovf_d        = ovf_q;
    pe_en_d      = 1'b0;
    pe_data_d    = pe_data_q;
    res_valid_d  = res_valid_q;
    res_score_d  = res_score_q;
    res_len_d    = res_len_q;
    res_err_d    = res_err_q;
    mem_we       = 1'b0;
    start_stream = 1'b0;
`ifdef SW_FEEDER_TIMEOUT_EN
    wd_d         = wd_q;
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      StIdle, StLoad: begin
        if (s_valid) begin
          mem_we   = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (s_last) begin
            len_d        = wr_cnt_q + 1'b1;
            start_stream = 1'b1;
          end else if (wr_cnt_q == LastIdx) begin
            len_d   = DepthLen;
            ovf_d   = 1'b1;
            state_d = StDrain;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StDrain: begin
        // Surplus beats are swallowed without touching the buffer.
        if (s_valid && s_last) begin
          start_stream = 1'b1;
        end
      end
      StStream: begin
        if (rd_ptr_q < len_q) begin
          pe_en_d   = 1'b1;
          pe_data_d = mem[rd_ptr_q[AddrWidth-1:0]];
          rd_ptr_d  = rd_ptr_q + 1'b1;
        end else begin
          state_d = StWaitVld;
`ifdef SW_FEEDER_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
      end
      StWaitVld: begin
        if (pe_vld_in) begin
          res_valid_d = 1'b1;
          res_len_d   = len_q;
          res_err_d   = ovf_q | timeout_q;
          // Scores below the bias clamp to zero.
          res_score_d = (pe_high_in >= ZeroScore) ? (pe_high_in - ZeroScore) : '0;
          state_d     = StResult;
        end
`ifdef SW_FEEDER_TIMEOUT_EN
        else if (wd_q == wd_limit - 1'b1) begin
          timeout_d   = 1'b1;
          res_valid_d = 1'b1;
          res_len_d   = len_q;
          res_err_d   = 1'b1;
          res_score_d = '0;
          state_d     = StResult;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ovf_d       = 1'b0;
          wr_cnt_d    = '0;
          state_d     = StIdle;
`ifdef SW_FEEDER_TIMEOUT_EN
          timeout_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // The burst starts on the edge that accepts the last beat. A one-beat target
    // has not reached the buffer yet, so it is forwarded straight from the input.
    if (start_stream) begin
      state_d   = StStream;
      pe_en_d   = 1'b1;
      rd_ptr_d  = LEN_WIDTH'(1);
      pe_data_d = (wr_cnt_q == '0) ? s_base : mem[FirstAddr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      len_q       <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      pe_en_q     <= 1'b0;
      pe_data_q   <= 2'b00;
      res_valid_q <= 1'b0;
      res_score_q <= '0;
      res_len_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      len_q       <= len_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      pe_en_q     <= pe_en_d;
      pe_data_q   <= pe_data_d;
      res_valid_q <= res_valid_d;
      res_score_q <= res_score_d;
      res_len_q   <= res_len_d;
      res_err_q   <= res_err_d;
    end
  end

`ifdef SW_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  // Buffer needs no reset: wr_cnt and len decide what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_cnt_q[AddrWidth-1:0]] <= s_base;
    end
  end

endmodule

// File: tb/tb_sw_target_feeder.sv
// Testbench for sw_target_feeder. A queue-based reference model predicts every
// output cycle by cycle. Directed scenarios use literal expectations, and
// randomized targets are checked against the model.
module tb_sw_target_feeder;

  localparam int SW    = 12;
  localparam int ZERO  = 2048;
  localparam int NPE   = 4;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  localparam int MCollect = 0;
  localparam int MDrain   = 1;
  localparam int MStream  = 2;
  localparam int MWait    = 3;
  localparam int MResult  = 4;

  logic          clk        = 1'b0;
  logic          rst        = 1'b0;
  logic          s_valid    = 1'b0;
  logic [1:0]    s_base     = 2'b00;
  logic          s_last     = 1'b0;
  logic [SW-1:0] pe_high_in = '0;
  logic          pe_vld_in  = 1'b0;
  logic          res_ready  = 1'b0;

  logic          s_ready;
  logic          pe_en;
  logic [1:0]    pe_data;
  logic [SW-1:0] pe_M, pe_I, pe_High;
  logic          res_valid;
  logic [SW-1:0] res_score;
  logic [LW-1:0] res_len;
  logic          res_err;
  logic          busy;

  sw_target_feeder #(
    .SCORE_WIDTH(SW),
    .ZERO       (ZERO),
    .NUM_PE     (NPE),
    .BUF_DEPTH  (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_base    (s_base),
    .s_last    (s_last),
    .pe_en     (pe_en),
    .pe_data   (pe_data),
    .pe_M      (pe_M),
    .pe_I      (pe_I),
    .pe_High   (pe_High),
    .pe_high_in(pe_high_in),
    .pe_vld_in (pe_vld_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_score (res_score),
    .res_len   (res_len),
    .res_err   (res_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_mode = MCollect;
  logic [1:0] m_tgt[$];
  logic [1:0] m_burst[$];
  bit         m_ovf  = 1'b0;
  int         m_wait = 0;
  bit         m_live = 1'b0;
  bit         e_en   = 1'b0;
  logic [1:0] e_data = 2'b00;
  bit         e_rv   = 1'b0;
  int         e_score = 0;
  int         e_len   = 0;
  bit         e_err   = 1'b0;

  task automatic start_burst();
    m_burst = m_tgt;
    e_en    = 1'b1;
    e_data  = m_burst.pop_front();
    m_mode  = MStream;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_mode = MCollect;
        m_tgt.delete();
        m_burst.delete();
        m_ovf   = 1'b0;
        m_wait  = 0;
        e_en    = 1'b0;
        e_data  = 2'b00;
        e_rv    = 1'b0;
        e_score = 0;
        e_len   = 0;
        e_err   = 1'b0;
        m_live  = 1'b1;
      end else begin
        case (m_mode)
          MCollect: begin
            if (s_valid) begin
              m_tgt.push_back(s_base);
              if (s_last) start_burst();
              else if (m_tgt.size() == DEPTH) begin
                m_ovf  = 1'b1;
                m_mode = MDrain;
              end
            end
          end
          MDrain: if (s_valid && s_last) start_burst();
          MStream: begin
            if (m_burst.size() > 0) e_data = m_burst.pop_front();
            else begin
              e_en   = 1'b0;
              m_mode = MWait;
              m_wait = 0;
            end
          end
          MWait: begin
            if (pe_vld_in) begin
              e_rv    = 1'b1;
              e_score = (int'(pe_high_in) >= ZERO) ? int'(pe_high_in) - ZERO : 0;
              e_len   = m_tgt.size();
              e_err   = m_ovf;
              m_mode  = MResult;
            end
`ifdef SW_FEEDER_TIMEOUT_EN
            else begin
              m_wait++;
              if (m_wait == m_tgt.size() + 2 * NPE + 8) begin
                e_rv    = 1'b1;
                e_score = 0;
                e_len   = m_tgt.size();
                e_err   = 1'b1;
                m_mode  = MResult;
              end
            end
`endif
          end
          MResult: begin
            if (res_ready) begin
              e_rv   = 1'b0;
              m_ovf  = 1'b0;
              m_tgt.delete();
              m_mode = MCollect;
            end
          end
          default: m_mode = MCollect;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("pe_en", int'(pe_en), int'(e_en));
        if (e_en) chk("pe_data", int'(pe_data), int'(e_data));
        chk("s_ready", int'(s_ready), int'(m_mode == MCollect || m_mode == MDrain));
        chk("busy", int'(busy), int'(!(m_mode == MCollect && m_tgt.size() == 0)));
        chk("res_valid", int'(res_valid), int'(e_rv));
        if (e_rv) begin
          chk("res_score", int'(res_score), e_score);
          chk("res_len", int'(res_len), e_len);
          chk("res_err", int'(res_err), int'(e_err));
        end
        chk("pe_M", int'(pe_M), ZERO);
        chk("pe_I", int'(pe_I), ZERO);
        chk("pe_High", int'(pe_High), ZERO);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] tx[32];

  // Called at a negedge; returns at the negedge just after the last accept.
  task automatic send(input int n, input int gap_max);
    int budget;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_max, 0)) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_base  = tx[i];
      s_last  = (i == n - 1);
      budget  = 0;
      while (!s_ready && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      if (!s_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: s_ready=0 after %0d cycles, required 1", budget);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_mode(input int md, input int budget, input string nm);
    int c = 0;
    while (m_mode != md && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (m_mode != md) begin
      checks++;
      errors++;
      $display("FAIL %s: bound of %0d cycles expired, mode %0d, required %0d",
               nm, budget, m_mode, md);
    end
  endtask

  task automatic pulse_vld(input int v);
    pe_high_in = SW'(v);
    pe_vld_in  = 1'b1;
    @(negedge clk);
    pe_vld_in  = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  function automatic int rand_score();
    if ($urandom_range(1, 0) == 1) return int'($urandom_range(4095, 0));
    return int'($urandom_range(2060, 2036));
  endfunction

  task automatic run_txn(input int n, input bit vld_in_stream, input int rdy_delay);
    for (int i = 0; i < n; i++) tx[i] = 2'($urandom_range(3, 0));
    if ($urandom_range(1, 0) == 1) pulse_vld(rand_score());  // ignored while idle
    send(n, 2);
    if (vld_in_stream) pulse_vld(rand_score());               // ignored while streaming
    wait_mode(MWait, 200, "stream_end");
    repeat ($urandom_range(5, 0)) @(negedge clk);
    pulse_vld(rand_score());
    wait_mode(MResult, 4, "result_wait");
    repeat (rdy_delay) @(negedge clk);
    handshake();
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pe_en", int'(pe_en), 0);
    chk("rst_pe_data", int'(pe_data), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_score", int'(res_score), 0);
    chk("rst_res_len", int'(res_len), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_pe_M", int'(pe_M), 2048);
    rst = 1'b1;

    // A,G,T,C burst
    tx[0] = 2'b00; tx[1] = 2'b01; tx[2] = 2'b10; tx[3] = 2'b11;
    send(4, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pe_en", int'(pe_en), 1);
      chk("t1_pe_data", int'(pe_data), i);
      chk("t1_pe_High", int'(pe_High), 2048);
      @(negedge clk);
    end
    chk("t1_pe_en_fall", int'(pe_en), 0);

    // Result held while res_ready is low
    pulse_vld(2056);
    for (int i = 0; i < 5; i++) begin
      chk("t2_res_valid", int'(res_valid), 1);
      chk("t2_res_score", int'(res_score), 8);
      chk("t2_res_len", int'(res_len), 4);
      chk("t2_res_err", int'(res_err), 0);
      @(negedge clk);
    end
    handshake();
    chk("t2_s_ready", int'(s_ready), 1);
    chk("t2_busy", int'(busy), 0);

    // Overflow: 10 beats into an 8-deep buffer
    for (int i = 0; i < 10; i++) tx[i] = 2'($urandom_range(3, 0));
    send(10, 0);
    for (int i = 0; i < 8; i++) begin
      chk("t3_pe_en", int'(pe_en), 1);
      chk("t3_pe_data", int'(pe_data), int'(tx[i]));
      @(negedge clk);
    end
    chk("t3_pe_en_fall", int'(pe_en), 0);
    pulse_vld(2050);
    chk("t3_res_score", int'(res_score), 2);
    chk("t3_res_len", int'(res_len), 8);
    chk("t3_res_err", int'(res_err), 1);
    handshake();

    // Valid during stream is ignored; below-bias score clamps to 0
    for (int i = 0; i < 5; i++) tx[i] = 2'($urandom_range(3, 0));
    send(5, 0);
    pulse_vld(2100);
    chk("t4_no_result", int'(res_valid), 0);
    chk("t4_still_stream", int'(pe_en), 1);
    wait_mode(MWait, 20, "t4_stream_end");
    pulse_vld(2047);
    chk("t4_res_valid", int'(res_valid), 1);
    chk("t4_res_score", int'(res_score), 0);
    chk("t4_res_len", int'(res_len), 5);
    chk("t4_res_err", int'(res_err), 0);
    handshake();

    // Reset on the 2nd stream cycle of a 6-base target
    for (int i = 0; i < 6; i++) tx[i] = 2'($urandom_range(3, 0));
    send(6, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_pe_en", int'(pe_en), 0);
    chk("t5_res_valid", int'(res_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_s_ready", int'(s_ready), 1);
    run_txn(3, 1'b0, 0);

    // Randomized targets, including overflow lengths
    for (int t = 0; t < 40; t++) begin
      run_txn(int'($urandom_range(12, 1)), 1'($urandom_range(1, 0)),
              int'($urandom_range(4, 0)));
    end

    // No valid from the chain at all
    tx[0] = 2'b11; tx[1] = 2'b10; tx[2] = 2'b01; tx[3] = 2'b00;
    send(4, 0);
    repeat (4) @(negedge clk);
`ifdef SW_FEEDER_TIMEOUT_EN
    begin
      int n = 0;
      while (!res_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("wd_cycles", n, 20);
      chk("wd_res_score", int'(res_score), 0);
      chk("wd_res_err", int'(res_err), 1);
      chk("wd_res_len", int'(res_len), 4);
      handshake();
    end
`else
    repeat (1000) @(negedge clk);
    chk("nowd_res_valid", int'(res_valid), 0);
    chk("nowd_busy", int'(busy), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("nowd_s_ready", int'(s_ready), 1);
`endif
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sw_target_feeder.md
# sw_target_feeder

Head-end driver for the Smith-Waterman systolic PE chain. Loads one target sequence (2-bit bases) from an upstream valid/ready stream into a local buffer, then drives it into the first PE as an unbroken enable burst with biased-zero boundary scores. It waits for the last PE's valid flag and returns the unbiased high score on a result valid/ready port. One sequence is in flight at a time.

## Interface
- SCORE_WIDTH, 12, score width; must match the PE chain
- ZERO, 2**(SCORE_WIDTH-1), biased zero
- NUM_PE, 16, PEs in the chain; sizes the timeout
- BUF_DEPTH, 256, maximum target length in bases (power of two)
- LEN_WIDTH, 9, length field width; holds the value BUF_DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- s_valid  in  1  upstream base valid
- s_ready  out  1  feeder accepts a base
- s_base  in  2  base, A=00 G=01 T=10 C=11
- s_last  in  1  final base of target
- pe_en  out  1  en_in of first PE
- pe_data  out  2  data_in of first PE
- pe_M, pe_I, pe_High  out  SCORE_WIDTH each  M_in/I_in/High_in of first PE; constant ZERO
- pe_high_in  in  SCORE_WIDTH  High_out of last PE
- pe_vld_in  in  1  vld of last PE
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_score  out  SCORE_WIDTH  unbiased high score
- res_len  out  LEN_WIDTH  bases streamed
- res_err  out  1  overflow or timeout
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, DRAIN, STREAM, WAIT_VLD, RESULT.
- IDLE/LOAD: s_ready=1. Each accepted beat writes buf[wr_cnt] and increments wr_cnt. IDLE goes to LOAD on the first accept.
- An accepted beat with s_last goes to STREAM and latches len=wr_cnt+1. A single-beat target with s_last set in IDLE goes straight to STREAM, len=1.
- Overflow: when the BUF_DEPTH-th beat is accepted without s_last, latch len=BUF_DEPTH and set the sticky ovf flag.
  - The FSM goes to DRAIN.
  - DRAIN keeps s_ready=1 and discards beats until an accepted s_last, then goes to STREAM.
- STREAM: s_ready=0. pe_en=1 for exactly len consecutive cycles; pe_data=buf[0]..buf[len-1] in order. Then go to WAIT_VLD with pe_en=0.
- WAIT_VLD: pe_en=0. On pe_vld_in=1, capture the score and go to RESULT.
  - Captured score: res_score = pe_high_in-ZERO if pe_high_in>=ZERO, else 0.
  - pe_vld_in is ignored in every other state.
- RESULT: res_valid=1. res_score, res_len and res_err (ovf | timeout) are held stable until res_ready=1. On the handshake go to IDLE and clear ovf, timeout and wr_cnt.
- pe_M/pe_I/pe_High are ZERO at all times, including reset.

## Timing
- All outputs are registered except s_ready and busy, which decode the state register.
- Reset values:
  - pe_en=0, pe_data=00
  - res_valid=0, res_score=0, res_len=0, res_err=0
  - state=IDLE, so s_ready=1 and busy=0
- Reset mid-operation aborts the transfer and discards buffer contents. pe_en=0 on the cycle after the reset edge.
- The last beat is accepted at edge k. The first pe_en=1 cycle (pe_data=buf[0]) begins at edge k+1. pe_en falls at edge k+1+len.
- pe_en is never low inside a burst. It is low for at least one cycle between bursts, which is guaranteed by WAIT_VLD/RESULT.
- pe_vld_in seen at edge j gives res_valid=1 from edge j+1.
- res_valid&res_ready at edge r gives IDLE at r+1, with s_ready=1 at r+1. A new beat may be accepted in that cycle.
- Buffer read is combinational from the read pointer, registered into pe_data. Memory may be distributed RAM or flops.

## Configuration
- SW_FEEDER_TIMEOUT_EN defined:
  - WAIT_VLD runs a watchdog counter sized to hold len+2*NUM_PE+8.
  - If that many cycles pass without pe_vld_in, go to RESULT with res_score=0 and timeout=1 (res_err=1).
- SW_FEEDER_TIMEOUT_EN undefined:
  - No counter; WAIT_VLD waits indefinitely.
  - timeout is constant 0; res_err reflects ovf only.

## Test plan
- Send A,G,T,C (00,01,10,11, s_last on C) -> pe_en high exactly 4 cycles starting the cycle after the last accept; pe_data 00,01,10,11; pe_M=pe_I=pe_High=2048 throughout.
- After test 1, pulse pe_vld_in with pe_high_in=2056 and hold res_ready=0 for 5 cycles -> res_valid=1, res_score=8, res_len=4, res_err=0, all stable for the 5 cycles; res_ready=1 -> IDLE and s_ready=1 next cycle.
- Overflow, BUF_DEPTH=8: send 10 beats with s_last on the 10th -> all 10 accepted; pe_en high 8 cycles carrying beats 1-8; res_len=8, res_err=1.
- pe_vld_in with pe_high_in=2047 -> res_score=0. Also pulse pe_vld_in during STREAM -> ignored, no result.
- Assert rst=0 on the 2nd STREAM cycle of a 6-base target -> pe_en=0 and res_valid=0 next cycle; after release, s_ready=1 and a new 3-base target streams normally.
- With SW_FEEDER_TIMEOUT_EN, NUM_PE=4, len=4: never pulse pe_vld_in -> res_valid=1 exactly 20 cycles after entering WAIT_VLD, res_score=0, res_err=1. Without the macro, res_valid stays 0 for 1000 cycles.
